// File: rtl/pe_seq.sv
// ---------------------------------------------------------------------------
// pe_seq -- microsequencer for one GF(3^97) processing element.
//
// Accepts an operation request (MULT or CUBE) over a start/busy/done
// handshake and drives the PE's 11-bit control word cycle by cycle:
//   MULT : LOAD, then STEPS Horner steps (first step clears the accumulator)
//   CUBE : LOAD, then a single cube-accumulate step
// One instance sits between the pairing scheduler and each PE.
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   reset  in   asynchronous, active-low reset
//   start  in   request strobe, only looked at while idle
//   op     in   2'b00 MULT, 2'b01 CUBE, 2'b1x reserved (err pulse)
//   abort  in   synchronous cancel, active-high, ignored while idle
//   ctrl   out  PE control word {c0..c10}, c0 = bit 10, c10 = bit 0
//   ld     out  high during the LOAD cycle (host holds d0/d1/d2 stable)
//   busy   out  high in LOAD, RUN and DONE
//   done   out  one-cycle pulse, PE result register valid
//   err    out  one-cycle pulse after a request with a reserved op
//
// Every output is a register whose next value is decoded from the next
// state, so outputs always describe the current state with no comb path
// from the inputs.
// ---------------------------------------------------------------------------
module pe_seq #(
    parameter int STEPS  = 33,
    parameter int CTRL_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              abort,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ld,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Control word constants. Bit 10 is c0, bit 0 is c10.
    //   LOAD   : c0..c4, R1<=d1, R2<=d2, R0<=d0
    //   MFIRST : c5,c6,c9,c10; c8 low drops the R3 term, which clears the
    //            accumulator on the first Horner step
    //   MITER  : c5..c10, R3 <= ppg0 + x*ppg1 + x^2*ppg2 + x^3*R3, R0 >>= 6
    //   CUBE   : c8,c10, R3 <= cu0 + cu1 + cu2 + R3
    localparam logic [CTRL_W-1:0] CW_IDLE   = CTRL_W'(11'h000);
    localparam logic [CTRL_W-1:0] CW_LOAD   = CTRL_W'(11'h7C0);
    localparam logic [CTRL_W-1:0] CW_MFIRST = CTRL_W'(11'h033);
    localparam logic [CTRL_W-1:0] CW_MITER  = CTRL_W'(11'h03F);
    localparam logic [CTRL_W-1:0] CW_CUBE   = CTRL_W'(11'h005);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               cube_q,  cube_d;   // latched op: 1 = CUBE, 0 = MULT
    logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
    logic               ld_q,    ld_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    // Maps a state (plus step counter and latched op in RUN) to its control
    // word. Every state, including unused encodings, lands on a constant.
    function automatic logic [CTRL_W-1:0] ctrl_of(input state_t           st,
                                                  input logic [CNT_W-1:0] cnt,
                                                  input logic             cube);
        logic [CTRL_W-1:0] cw;
        cw = CW_IDLE;
        case (st)
            S_LOAD: cw = CW_LOAD;
            S_RUN: begin
                if (cube)
                    cw = CW_CUBE;
                else if (cnt == CNT_ZERO)
                    cw = CW_MFIRST;
                else
                    cw = CW_MITER;
            end
            default: cw = CW_IDLE;
        endcase
        return cw;
    endfunction

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cube_d  = cube_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op[1]) begin
                        // Reserved op: refuse it, stay idle, flag it.
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        cube_d  = op[0];
                    end
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                cnt_d   = CNT_ZERO;
            end
            S_RUN: begin
                // The counter only advances in a MULT run and the state
                // exits at CNT_LAST, so it can never wrap.
                if (cube_q || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Abort cancels any active operation and wins over everything else.
        // While idle it is a no-op, so start in the same cycle still counts.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        ctrl_d = ctrl_of(state_d, cnt_d, cube_d);
        ld_d   = (state_d == S_LOAD);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            cube_q  <= 1'b0;
            ctrl_q  <= CW_IDLE;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cube_q  <= cube_d;
            ctrl_q  <= ctrl_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ctrl = ctrl_q;
    assign ld   = ld_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pe_seq.sv
// ---------------------------------------------------------------------------
// tb_pe_seq -- directed, table-driven bench for pe_seq.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. they show the state entered on that edge.
// ---------------------------------------------------------------------------
module tb_pe_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        abort;
    logic [10:0] ctrl;
    logic        ld;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    pe_seq #(.STEPS(33), .CTRL_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .abort (abort),
        .ctrl  (ctrl),
        .ld    (ld),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [1:0]  op;
        logic        abort;
        logic [10:0] ctrl;
        logic        ld;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic s, input logic [1:0] o, input logic a,
                                input logic [10:0] c, input logic l, input logic b,
                                input logic d, input logic e);
        vec_t v;
        v.start = s; v.op = o; v.abort = a;
        v.ctrl = c; v.ld = l; v.busy = b; v.done = d; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic a);
        start = s;
        op    = o;
        abort = a;
    endtask

    // Expected ctrl for cycle c of a MULT started in cycle 0.
    function automatic logic [10:0] mult_ctrl(input int c);
        if (c == 1) return 11'h7C0;
        if (c == 2) return 11'h033;
        if (c >= 3 && c <= 34) return 11'h03F;
        return 11'h000;
    endfunction

    initial begin
        int ndone;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, 2'b00, 1'b0);

        // Rows: inputs applied during a cycle, outputs expected after the edge.
        // CUBE, then back-to-back CUBE (start during DONE ignored, accepted next cycle).
        tbl[0]  = mk(1, 2'b01, 0, 11'h7C0, 1, 1, 0, 0);
        tbl[1]  = mk(0, 2'b00, 0, 11'h005, 0, 1, 0, 0);
        tbl[2]  = mk(0, 2'b00, 0, 11'h000, 0, 1, 1, 0);
        tbl[3]  = mk(1, 2'b01, 0, 11'h000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 2'b01, 0, 11'h7C0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 2'b00, 0, 11'h005, 0, 1, 0, 0);
        tbl[6]  = mk(0, 2'b00, 0, 11'h000, 0, 1, 1, 0);
        tbl[7]  = mk(0, 2'b00, 0, 11'h000, 0, 0, 0, 0);
        // Reserved ops.
        tbl[8]  = mk(1, 2'b10, 0, 11'h000, 0, 0, 0, 1);
        tbl[9]  = mk(0, 2'b11, 0, 11'h000, 0, 0, 0, 0);
        tbl[10] = mk(1, 2'b11, 0, 11'h000, 0, 0, 0, 1);
        tbl[11] = mk(0, 2'b00, 0, 11'h000, 0, 0, 0, 0);
        // start+abort while idle is accepted; start+abort in LOAD returns to idle.
        tbl[12] = mk(1, 2'b01, 1, 11'h7C0, 1, 1, 0, 0);
        tbl[13] = mk(1, 2'b01, 1, 11'h000, 0, 0, 0, 0);
        tbl[14] = mk(0, 2'b00, 0, 11'h000, 0, 0, 0, 0);
        // Abort during a CUBE RUN: no done.
        tbl[15] = mk(1, 2'b01, 0, 11'h7C0, 1, 1, 0, 0);
        tbl[16] = mk(0, 2'b00, 0, 11'h005, 0, 1, 0, 0);
        tbl[17] = mk(0, 2'b00, 1, 11'h000, 0, 0, 0, 0);
        tbl[18] = mk(0, 2'b00, 0, 11'h000, 0, 0, 0, 0);
        // op changed after acceptance is ignored.
        tbl[19] = mk(1, 2'b01, 0, 11'h7C0, 1, 1, 0, 0);
        tbl[20] = mk(0, 2'b00, 0, 11'h005, 0, 1, 0, 0);
        tbl[21] = mk(0, 2'b00, 0, 11'h000, 0, 1, 1, 0);
        tbl[22] = mk(0, 2'b00, 0, 11'h000, 0, 0, 0, 0);

        // Reset state.
        #12;
        chk("rst ctrl", 32'(ctrl), 32'h000);
        chk("rst busy", 32'(busy), 0);
        chk("rst ld",   32'(ld),   0);
        chk("rst done", 32'(done), 0);
        chk("rst err",  32'(err),  0);
        reset = 1'b1;
        tick();
        chk("idle busy", 32'(busy), 0);

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].start, tbl[i].op, tbl[i].abort);
            tick();
            chk($sformatf("row%0d ctrl", i), 32'(ctrl), 32'(tbl[i].ctrl));
            chk($sformatf("row%0d ld",   i), 32'(ld),   32'(tbl[i].ld));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d err",  i), 32'(err),  32'(tbl[i].err));
        end
        drive(1'b0, 2'b00, 1'b0);
        tick();

        // MULT with start held/pulsing every cycle and op changing mid-run.
        ndone = 0;
        drive(1'b1, 2'b00, 1'b0);
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (done) ndone++;
            chk($sformatf("mult c%0d ctrl", c), 32'(ctrl), 32'(mult_ctrl(c)));
            chk($sformatf("mult c%0d ld", c),   32'(ld),   (c == 1) ? 1 : 0);
            chk($sformatf("mult c%0d busy", c), 32'(busy), (c <= 35) ? 1 : 0);
            chk($sformatf("mult c%0d done", c), 32'(done), (c == 35) ? 1 : 0);
            chk($sformatf("mult c%0d err", c),  32'(err),  0);
            drive((c < 36) ? 1'b1 : 1'b0, 2'(c % 3), 1'b0);
        end
        chk("mult done count", 32'(ndone), 1);
        drive(1'b0, 2'b00, 1'b0);
        tick();

        // Abort at RUN counter 5 (cycle 7).
        drive(1'b1, 2'b00, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            drive(1'b0, 2'b00, 1'b0);
        end
        chk("abort pre ctrl", 32'(ctrl), 32'h03F);
        drive(1'b0, 2'b00, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b0);
        chk("abort ctrl", 32'(ctrl), 32'h000);
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort no activity", 32'(ndone), 0);

        // A fresh MULT after the abort starts from MFIRST.
        drive(1'b1, 2'b00, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0);
        tick();
        chk("post-abort mfirst", 32'(ctrl), 32'h033);

        // Reset mid-RUN at counter 10 (cycle 12 of this run = 10 more cycles).
        for (int c = 3; c <= 12; c++) tick();
        chk("prerst ctrl", 32'(ctrl), 32'h03F);
        chk("prerst busy", 32'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst ctrl", 32'(ctrl), 32'h000);
        chk("async rst busy", 32'(busy), 0);
        chk("async rst ld",   32'(ld),   0);
        tick();
        chk("in rst ctrl", 32'(ctrl), 32'h000);
        reset = 1'b1;
        tick();
        chk("post rst ctrl", 32'(ctrl), 32'h000);
        chk("post rst busy", 32'(busy), 0);
        chk("post rst done", 32'(done), 0);
        chk("post rst err",  32'(err),  0);

        // A CUBE after reset runs normally.
        drive(1'b1, 2'b01, 1'b0);
        tick();
        drive(1'b0, 2'b00, 1'b0);
        chk("post rst load", 32'(ctrl), 32'h7C0);
        tick();
        chk("post rst cube", 32'(ctrl), 32'h005);
        tick();
        chk("post rst done pulse", 32'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_seq.md
Name: pe_seq

Overview:
- Microsequencer for one GF(3^97) processing element (PE).
- Accepts an operation request over a start/busy/done handshake.
- Drives the PE's 11-bit control word cycle by cycle: operand load, 33 Horner multiply steps (three base-3 digits per step), or a single cube-accumulate step.
- Sits between the pairing top-level scheduler and the PE; one instance per PE.

Parameters:
- STEPS, 33, multiply iterations (99 digits / 3 per step); counter width is derived from it.
- CTRL_W, 11, PE control word width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 CUBE, 1x reserved.
- abort  in  1  synchronous cancel, active-high.
- ctrl  out  11  PE control word {c0..c10}, where c0 is bit 10 and c10 is bit 0. Registered output.
- ld  out  1  high in the LOAD cycle; the host must present d0/d1/d2 stable during it.
- busy  out  1  high in LOAD, RUN and DONE.
- done  out  1  one-cycle pulse; PE result register valid.
- err  out  1  one-cycle pulse on a reserved op.

Behaviour:
- Reset (reset=0, async): state=IDLE, ctrl=0x000, ld=0, busy=0, done=0, err=0, step counter=0.
- Control word constants:
  - IDLE 0x000.
  - LOAD 0x7C0 (c0..c4: R1<=d1, R2<=d2, R0<=d0).
  - MFIRST 0x033 (c5, c6, c9, c10; c8=0, so the R3 term is excluded and the accumulator is implicitly cleared).
  - MITER 0x03F (c5..c10: R3 <= ppg0 + x*ppg1 + x^2*ppg2 + x^3*R3, shift R0 by 6).
  - CUBE 0x005 (c8, c10: R3 <= cu0 + cu1 + cu2 + R3).
- States: IDLE, LOAD, RUN, DONE. All outputs are registered and reflect the current state.
- IDLE:
  - start=1 with op=0x goes to LOAD next cycle.
  - start=1 with op=1x stays in IDLE and pulses err the next cycle (ctrl stays 0).
  - start=0 holds.
  - op is latched at start acceptance; later op changes are ignored.
- LOAD: one cycle, ctrl=LOAD, ld=1. Then go to RUN with counter=0.
- RUN, MULT:
  - Counter 0 emits MFIRST; counters 1..STEPS-1 emit MITER.
  - After counter=STEPS-1, go to DONE.
  - Total RUN cycles = 33.
- RUN, CUBE: one cycle emitting CUBE, then DONE.
- DONE: ctrl=0x000, done=1, busy=1 for one cycle, then IDLE.
- Latency with start accepted in cycle 0:
  - MULT: done in cycle 35.
  - CUBE: done in cycle 3.
  - A new start is accepted in IDLE the cycle after DONE at the earliest.
- start while busy=1 is ignored and is not queued.
- abort=1 in LOAD, RUN or DONE: next cycle is IDLE, ctrl=0, no done pulse, counter cleared. abort in IDLE has no effect. abort has priority over start in the same cycle.
- Reset asserted mid-operation forces IDLE immediately (async). ctrl=0x000 while reset is low.
- Counter never wraps. It is only incremented in MULT RUN and saturates logic-wise at STEPS-1 via the state exit.
- ctrl bits are never X: every state decodes to one of the five constants.

Test Plan:
- Reset: assert reset=0 mid-RUN at counter=10 -> same edge ctrl=0x000, busy=0; after release, idle with done=0, err=0.
- MULT: start with op=00 at cycle 0 -> cycle 1 ctrl=0x7C0, ld=1; cycle 2 ctrl=0x033; cycles 3..34 ctrl=0x03F (32 cycles); cycle 35 done=1, ctrl=0. With a PE attached and d1=d2=1, d0 encoding 1 -> R3=1.
- CUBE: start with op=01 -> cycle 1 0x7C0, cycle 2 0x005, cycle 3 done=1. Back-to-back CUBE requests accepted at cycle 4 -> second done at cycle 7.
- Reserved: start with op=10 and op=11 -> err=1 for one cycle each, busy stays 0, ctrl stays 0x000.
- Abort: abort=1 at RUN counter=5 -> next cycle ctrl=0x000, busy=0, no done. start with abort=1 in the same IDLE cycle -> accepted. start with abort=1 during LOAD -> return to IDLE.
- Ignored start: start pulses every cycle during a MULT -> exactly one done at cycle 35, and the op change mid-run has no effect.
